sr_rx_deser: RTL and testbench
==============================

SR_RX_DESER -- requirements
Module: sr_rx_deser

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, giving the payload bits per frame (legal 4..32).
REQ-002 The block SHALL have parameter HDR, default 8'hA5, giving the 8-bit frame header pattern.
REQ-003 The block SHALL have port clk_in, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port clk_4, input, 1 bit: the divided bit clock from the serializer, synchronous to clk_in.
REQ-006 The block SHALL have port sr_in, input, 1 bit: serial data, MSB first, stable around each clk_4 rising edge.
REQ-007 The block SHALL have port data_out, output, WORD_W bits: the last complete payload word.
REQ-008 The block SHALL have port data_valid, output, 1 bit: a one-cycle pulse when data_out is updated.
REQ-009 The block SHALL have port locked, output, 1 bit: high while frame alignment is held.
REQ-010 The block SHALL have port frame_err, output, 1 bit: a one-cycle pulse on a header mismatch while locked.

Function
REQ-011 The block SHALL register clk_4 into clk_4_d and form bit_stb = clk_4 & ~clk_4_d; sr_in is sampled only in cycles where bit_stb=1.
REQ-012 The block SHALL shift each sampled bit into an 8-bit header shift register and a WORD_W-bit payload shift register, MSB first.
REQ-013 The FSM SHALL have states HUNT, DATA and HDR; the reset state is HUNT.
REQ-014 In HUNT, when a sample makes the last 8 sampled bits equal HDR, the FSM SHALL go to DATA, set locked=1 and clear the bit counter.
REQ-015 In DATA, after WORD_W samples the FSM SHALL go to HDR and load data_out with the payload register.
REQ-016 The data_valid pulse SHALL be asserted in the cycle after the strobe of the last payload bit, for exactly one clk_in cycle.
REQ-017 In HDR, after 8 samples the FSM SHALL compare them with HDR; on a match it SHALL go to DATA, with locked staying 1.
REQ-018 On a mismatch in HDR, the block SHALL pulse frame_err for one cycle, clear locked, go to HUNT, and leave data_out unchanged.
REQ-019 HUNT SHALL compare on every sample, with no bit-count restriction, so a header is found at any bit offset.
REQ-020 The bit counter SHALL be wide enough for max(WORD_W, 8) and SHALL never wrap inside a state.
REQ-021 If clk_4 stops, the block SHALL hold its state indefinitely, with no timeout.
REQ-022 data_valid and frame_err SHALL never be asserted in the same cycle.

Reset
REQ-023 Asserting rst_n=0 SHALL immediately force HUNT, locked=0, data_valid=0, frame_err=0, data_out=0, clk_4_d=0, all counters to 0 and all shift registers to 0.
REQ-024 A reset in the middle of a frame SHALL discard the partial word, and the block SHALL re-hunt after rst_n rises.
REQ-025 rst_n SHALL be asynchronous on assertion; no synchronous reset path SHALL exist.

Configuration
REQ-026 With macro SR_RX_ERRCNT_EN defined, the block SHALL add output err_cnt[7:0], incremented on each frame_err pulse and saturating at 8'hFF.
REQ-027 With SR_RX_ERRCNT_EN defined, err_cnt SHALL reset to 0.
REQ-028 Without SR_RX_ERRCNT_EN, the err_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench: clk_in period 20 ns, clk_4 = clk_in/4; stream HDR A5 then 16'h1234 -> one data_valid, data_out=16'h1234, locked=1 from the header's last bit.
REQ-030 Bench: 3 random junk bits, then A5/16'hBEEF/A5/16'h0F0F -> two data_valid pulses, with values BEEF then 0F0F, and no frame_err.
REQ-031 Bench: A5/16'hCAFE followed by header 8'hA4 -> data_valid for CAFE, then a frame_err pulse, locked=0 and data_out holding CAFE; a following A5/16'h0001 relocks and outputs 0001.
REQ-032 Bench: rst_n pulled low 5 payload bits into 16'hFFFF -> outputs at reset values at once; after release, no data_valid occurs until a new A5 header.
REQ-033 Bench: with SR_RX_ERRCNT_EN, 300 consecutive header mismatches -> err_cnt=8'hFF, with no wrap.
REQ-034 Bench: clk_4 held high for 100 clk_in cycles mid-payload -> no state change; after resume, the word completes with the correct value.

Source files
------------

// File: rtl/sr_rx_deser.sv
// sr_rx_deser: serial frame deserializer (HDR header + WORD_W payload, MSB first, sampled on clk_4 rising edges); outputs data_out/data_valid/locked/frame_err, plus err_cnt when SR_RX_ERRCNT_EN is defined
module sr_rx_deser #(
  parameter int         WORD_W = 16,
  parameter logic [7:0] HDR    = 8'hA5
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              clk_4,
  input  logic              sr_in,
  output logic [WORD_W-1:0] data_out,
  output logic              data_valid,
  output logic              locked,
  output logic              frame_err
`ifdef SR_RX_ERRCNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);
  localparam int CW = $clog2((WORD_W > 8 ? WORD_W : 8) + 1);
  typedef enum logic [1:0] {ST_HUNT, ST_DATA, ST_HDR} state_t;
  state_t            state;
  logic              clk_4_d, bit_stb, unused_msb;
  logic [7:0]        hdr_sr, hdr_nx;
  logic [WORD_W-1:0] pay_sr, pay_nx;
  logic [CW-1:0]     cnt;
  assign bit_stb    = clk_4 & ~clk_4_d;
  assign hdr_nx     = {hdr_sr[6:0], sr_in};
  assign pay_nx     = {pay_sr[WORD_W-2:0], sr_in};
  assign unused_msb = hdr_sr[7] ^ pay_sr[WORD_W-1];
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state      <= ST_HUNT;
      clk_4_d    <= 1'b0;
      hdr_sr     <= '0;
      pay_sr     <= '0;
      cnt        <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      locked     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_4_d    <= clk_4;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_stb) begin
        hdr_sr <= hdr_nx;
        pay_sr <= pay_nx;
        case (state)
          ST_HUNT:
            if (hdr_nx == HDR) begin
              state  <= ST_DATA;
              locked <= 1'b1;
              cnt    <= '0;
            end
          ST_DATA:
            if (cnt == CW'(WORD_W - 1)) begin
              state      <= ST_HDR;
              data_out   <= pay_nx;
              data_valid <= 1'b1;
              cnt        <= '0;
            end else cnt <= cnt + 1'b1;
          ST_HDR:
            if (cnt == CW'(7)) begin
              cnt <= '0;
              if (hdr_nx == HDR) state <= ST_DATA;
              else begin
                state     <= ST_HUNT;
                locked    <= 1'b0;
                frame_err <= 1'b1;
              end
            end else cnt <= cnt + 1'b1;
          default: state <= ST_HUNT;
        endcase
      end
    end
`ifdef SR_RX_ERRCNT_EN
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) err_cnt <= '0;
    else if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
`endif
endmodule

// File: tb/tb_sr_rx_deser.sv
// tb_sr_rx_deser: scoreboard bench for sr_rx_deser driving directed serial frames
module tb_sr_rx_deser;
  localparam logic [7:0] H = 8'hA5;
  logic        clk_in, rst_n, clk_4, sr_in;
  logic [15:0] data_out;
  logic        data_valid, locked, frame_err;
`ifdef SR_RX_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif
  int          checks = 0, errors = 0;
  logic [16:0] exp_q[$];
  logic [16:0] got, e;
  sr_rx_deser dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_4(clk_4), .sr_in(sr_in),
    .data_out(data_out), .data_valid(data_valid), .locked(locked), .frame_err(frame_err)
`ifdef SR_RX_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  initial begin
    clk_in = 1'b0;
    forever #10 clk_in = ~clk_in;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic send_bit(input logic b);
    @(negedge clk_in);
    clk_4 = 1'b0;
    sr_in = b;
    repeat (2) @(negedge clk_in);
    clk_4 = 1'b1;
    repeat (2) @(negedge clk_in);
  endtask
  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic frame(input logic [15:0] w);
    send_bits(32'(H), 8);
    send_bits(32'(w), 16);
  endtask
  task automatic apply_reset();
    @(negedge clk_in);
    clk_4 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
  endtask
  always @(negedge clk_in)
    if (rst_n) begin
      if (data_valid && frame_err) chk("valid_and_ferr", 32'd1, 32'd0);
      if (data_valid || frame_err) begin
        got = data_valid ? {1'b0, data_out} : {1'b1, 16'h0000};
        if (exp_q.size() == 0) chk("unexpected_output", 32'(got), 32'h1FFFF);
        else begin
          e = exp_q.pop_front();
          chk("scoreboard", 32'(got), 32'(e));
        end
      end
    end
  initial begin
    rst_n = 1'b0;
    clk_4 = 1'b0;
    sr_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_ferr", 32'(frame_err), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
`ifdef SR_RX_ERRCNT_EN
    chk("rst_errcnt", 32'(err_cnt), 32'd0);
`endif
    @(negedge clk_in);
    rst_n = 1'b1;
    exp_q.push_back({1'b0, 16'h1234});
    send_bits(32'(H[7:1]), 7);
    chk("lock_before_last_hdr_bit", 32'(locked), 32'd0);
    send_bits(32'(H[0]), 1);
    chk("lock_on_last_hdr_bit", 32'(locked), 32'd1);
    send_bits(32'h1234, 16);
    chk("data_1234", 32'(data_out), 32'h1234);
    apply_reset();
    send_bits(32'b011, 3);
    exp_q.push_back({1'b0, 16'hBEEF});
    exp_q.push_back({1'b0, 16'h0F0F});
    frame(16'hBEEF);
    frame(16'h0F0F);
    chk("lock_after_two", 32'(locked), 32'd1);
    exp_q.push_back({1'b0, 16'hCAFE});
    frame(16'hCAFE);
    exp_q.push_back({1'b1, 16'h0000});
    send_bits(32'hA4, 8);
    @(negedge clk_in);
    chk("lock_after_bad_hdr", 32'(locked), 32'd0);
    chk("hold_cafe", 32'(data_out), 32'hCAFE);
    exp_q.push_back({1'b0, 16'h0001});
    frame(16'h0001);
    chk("relock", 32'(locked), 32'd1);
    chk("data_0001", 32'(data_out), 32'h0001);
    exp_q.push_back({1'b0, 16'h9C3E});
    send_bits(32'(H), 8);
    send_bits(32'h9C, 8);
    repeat (100) @(negedge clk_in);
    chk("stall_lock", 32'(locked), 32'd1);
    chk("stall_hold", 32'(data_out), 32'h0001);
    send_bits(32'h3E, 8);
    chk("stall_resume", 32'(data_out), 32'h9C3E);
    send_bits(32'(H), 8);
    send_bits(32'h1F, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_data", 32'(data_out), 32'd0);
    chk("arst_valid", 32'(data_valid), 32'd0);
    chk("arst_ferr", 32'(frame_err), 32'd0);
    @(negedge clk_in);
    clk_4 = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
`ifdef SR_RX_ERRCNT_EN
    chk("errcnt_after_reset", 32'(err_cnt), 32'd0);
`endif
    send_bits(32'h7FFFF, 19);
    chk("no_lock_after_reset", 32'(locked), 32'd0);
    exp_q.push_back({1'b0, 16'h5A5A});
    frame(16'h5A5A);
    chk("data_5a5a", 32'(data_out), 32'h5A5A);
`ifdef SR_RX_ERRCNT_EN
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back({1'b1, 16'h0000});
      send_bits(32'hA4, 8);
      exp_q.push_back({1'b0, 16'(i)});
      frame(16'(i));
    end
    repeat (4) @(negedge clk_in);
    chk("errcnt_saturate", 32'(err_cnt), 32'hFF);
`endif
    repeat (4) @(negedge clk_in);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
